// File: rtl/fpu_pkg.sv
// Shared FPU execute-stage types: op encoding, unit classes, exception layout and default latencies.
package fpu_pkg;

  localparam int unsigned FPU_NUM_UNITS = 6;
  localparam int unsigned FPU_EXC_W     = 6;
  localparam int unsigned FPU_FLAGS_W   = 5;

  localparam int unsigned FPU_LAT_ADD  = 3;
  localparam int unsigned FPU_LAT_MUL  = 3;
  localparam int unsigned FPU_LAT_DIV  = 9;
  localparam int unsigned FPU_LAT_SQRT = 9;
  localparam int unsigned FPU_LAT_CMP  = 2;

  typedef enum logic [3:0] {
    OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV, OP_FSQRT,
    OP_FEQ, OP_FLT, OP_FLE,
    OP_FMIN, OP_FMAX, OP_FSGNJ, OP_FMV, OP_FCVT, OP_FCLASS
  } fpuOp_t;

  typedef enum logic [2:0] {ADD, MUL, DIV, SQRT, CMP, COMB} fpuUnit_t;

  typedef struct packed {
    logic unimpl;
    logic invalid;
    logic div0;
    logic ovf;
    logic unf;
    logic inexact;
  } fpuExc6_t;

  // Width-independent part of a tracking entry; tag, data and countdown live in parameterised arrays.
  typedef struct packed {
    logic     valid;
    logic     done;
    fpuOp_t   op;
    fpuUnit_t unit;
    fpuExc6_t exc;
  } fpuPipeEntry_t;

endpackage

// File: rtl/fpu_op_class.sv
// Combinational op -> execution unit decode, shared with the decode stage.
module fpu_op_class
  import fpu_pkg::*;
(
  input  fpuOp_t   i_op,
  output fpuUnit_t o_unit_c
);

  always_comb begin
    o_unit_c = COMB;
    case (i_op)
      OP_FADD, OP_FSUB:        o_unit_c = ADD;
      OP_FMUL:                 o_unit_c = MUL;
      OP_FDIV:                 o_unit_c = DIV;
      OP_FSQRT:                o_unit_c = SQRT;
      OP_FEQ, OP_FLT, OP_FLE:  o_unit_c = CMP;
      default:                 o_unit_c = COMB;
    endcase
  end

endmodule

// File: rtl/fpu_pipe_ctrl.sv
// In-order issue/retire tracker for the FPU execute stage with fixed per-unit latencies
// and sticky FCSR exception flags.
module fpu_pipe_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned TAG_W         = 4,
  parameter int unsigned LAT_ADD       = FPU_LAT_ADD,
  parameter int unsigned LAT_MUL       = FPU_LAT_MUL,
  parameter int unsigned LAT_DIV       = FPU_LAT_DIV,
  parameter int unsigned LAT_SQRT      = FPU_LAT_SQRT,
  parameter int unsigned LAT_CMP       = FPU_LAT_CMP,
  parameter int unsigned DIV_PIPELINED = 0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   flush,
  input  logic                                   issue_valid,
  output logic                                   issue_ready,
  input  fpuOp_t                                 issue_op,
  input  logic [TAG_W-1:0]                       issue_tag,
  input  logic [DATA_W-1:0]                      issue_data,
  input  logic [FPU_EXC_W-1:0]                   issue_exc,
  input  logic [FPU_NUM_UNITS-1:0][DATA_W-1:0]   unit_res,
  input  logic [FPU_NUM_UNITS-1:0][FPU_EXC_W-1:0] unit_exc,
  output logic                                   retire_valid,
  input  logic                                   retire_ready,
  output fpuOp_t                                 retire_op,
  output logic [TAG_W-1:0]                       retire_tag,
  output logic [DATA_W-1:0]                      retire_data,
  output logic [FPU_EXC_W-1:0]                   retire_exc,
  input  logic                                   flags_clr,
  output logic [FPU_FLAGS_W-1:0]                 flags,
  output logic                                   fpu_busy
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned PTR_W1  = PTR_W + 1;
  localparam int unsigned MAX_AM  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
  localparam int unsigned MAX_DS  = (LAT_DIV > LAT_SQRT) ? LAT_DIV : LAT_SQRT;
  localparam int unsigned MAX_ADS = (MAX_AM > MAX_DS) ? MAX_AM : MAX_DS;
  localparam int unsigned MAX_LAT = (MAX_ADS > LAT_CMP) ? MAX_ADS : LAT_CMP;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  fpuPipeEntry_t       r_ent  [DEPTH];
  logic [CNT_W-1:0]    r_cnt  [DEPTH];
  logic [DATA_W-1:0]   r_data [DEPTH];
  logic [TAG_W-1:0]    r_tag  [DEPTH];
  logic [PTR_W:0]      r_wr_ptr;
  logic [PTR_W:0]      r_rd_ptr;
  logic [FPU_FLAGS_W-1:0] r_flags;

  fpuUnit_t            w_issue_unit;
  logic                w_full;
  logic                w_div_busy;
  logic                w_div_class;
  logic                w_push;
  logic                w_pop;
  logic [PTR_W-1:0]    w_wr_idx;
  logic [PTR_W-1:0]    w_rd_idx;
  fpuPipeEntry_t       w_head;
  logic [FPU_EXC_W-1:0] w_head_exc;

  function automatic logic [CNT_W-1:0] lat_of(input fpuUnit_t u);
    case (u)
      ADD:     return CNT_W'(LAT_ADD);
      MUL:     return CNT_W'(LAT_MUL);
      DIV:     return CNT_W'(LAT_DIV);
      SQRT:    return CNT_W'(LAT_SQRT);
      CMP:     return CNT_W'(LAT_CMP);
      default: return '0;
    endcase
  endfunction

  fpu_op_class u_op_class (
    .i_op     (issue_op),
    .o_unit_c (w_issue_unit)
  );

  assign w_wr_idx = r_wr_ptr[PTR_W-1:0];
  assign w_rd_idx = r_rd_ptr[PTR_W-1:0];
  assign w_full   = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) && (w_wr_idx == w_rd_idx);
  assign w_head   = r_ent[w_rd_idx];
  assign w_head_exc = w_head.exc;

  // The shared divider stays busy while any div/sqrt op is still counting down.
  always_comb begin
    w_div_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_ent[i].valid && (r_ent[i].unit == DIV || r_ent[i].unit == SQRT) && (r_cnt[i] != '0)) begin
        w_div_busy = 1'b1;
      end
    end
  end

  assign w_div_class  = (w_issue_unit == DIV) || (w_issue_unit == SQRT);
  assign issue_ready  = !w_full && !flush && !(w_div_busy && w_div_class && (DIV_PIPELINED == 0));
  assign w_push       = issue_valid && issue_ready;
  assign retire_valid = w_head.valid && w_head.done;
  assign w_pop        = retire_valid && retire_ready && !flush;

  assign retire_op   = retire_valid ? w_head.op : OP_FADD;
  assign retire_tag  = retire_valid ? r_tag[w_rd_idx] : '0;
  assign retire_data = retire_valid ? r_data[w_rd_idx] : '0;
  assign retire_exc  = retire_valid ? w_head_exc : '0;
  assign flags       = r_flags;
  assign fpu_busy    = (r_wr_ptr != r_rd_ptr);

  // Entry array: countdown, result capture on the last count, push at wr_ptr, pop at rd_ptr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i]  <= '0;
        r_cnt[i]  <= '0;
        r_data[i] <= '0;
        r_tag[i]  <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i].valid <= 1'b0;
        r_ent[i].done  <= 1'b0;
        r_cnt[i]       <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_ent[i].valid && (r_cnt[i] > CNT_W'(1))) begin
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
        end else if (r_ent[i].valid && (r_cnt[i] == CNT_W'(1))) begin
          r_cnt[i]       <= '0;
          r_ent[i].done  <= 1'b1;
          r_data[i]      <= unit_res[r_ent[i].unit];
          r_ent[i].exc   <= fpuExc6_t'(unit_exc[r_ent[i].unit]);
        end
      end
      if (w_pop) begin
        r_ent[w_rd_idx].valid <= 1'b0;
        r_ent[w_rd_idx].done  <= 1'b0;
        r_rd_ptr <= r_rd_ptr + PTR_W1'(1);
      end
      if (w_push) begin
        r_ent[w_wr_idx].valid <= 1'b1;
        r_ent[w_wr_idx].op    <= issue_op;
        r_ent[w_wr_idx].unit  <= w_issue_unit;
        r_tag[w_wr_idx]       <= issue_tag;
        r_cnt[w_wr_idx]       <= lat_of(w_issue_unit);
        if (w_issue_unit == COMB) begin
          r_ent[w_wr_idx].done <= 1'b1;
          r_ent[w_wr_idx].exc  <= fpuExc6_t'(issue_exc);
          r_data[w_wr_idx]     <= issue_data;
        end else begin
          r_ent[w_wr_idx].done <= 1'b0;
        end
        r_wr_ptr <= r_wr_ptr + PTR_W1'(1);
      end
    end
  end

  // Sticky flags: OR-in on pop; clear request loses to the popped op's own cause bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if (w_pop && flags_clr) begin
      r_flags <= w_head_exc[FPU_FLAGS_W-1:0];
    end else if (w_pop) begin
      r_flags <= r_flags | w_head_exc[FPU_FLAGS_W-1:0];
    end else if (flags_clr) begin
      r_flags <= '0;
    end
  end

endmodule
